gray_step_tracker: RTL
======================

# gray_step_tracker

Downstream consumer of the 3-bit Gray-code up/down counter FSM. It samples the counter's 3-bit Gray output every clock and converts it to binary. It classifies each transition as step-up, step-down, hold or illegal, and accumulates a wrapping position count. A lock FSM qualifies the incoming sequence, and illegal (multi-bit) transitions are counted and flagged for the display/checker logic that follows.

## Interface
- `POS_W`, default 8: width of position accumulator.
- `LOCK_N`, default 2: consecutive valid steps (up or down) required to reach LOCK; range 1..7.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `g` in 3: Gray code from the upstream counter (bits S2..S0 order, `g[2]` MSB).
- `clr` in 1: synchronous clear of position, error count and lock FSM.
- `bin` out 3: registered binary equivalent of the last sample.
- `pos` out `POS_W`: position accumulator, two's-complement wrap.
- `dir` out 1: direction of last valid step; 1 = up, 0 = down.
- `step` out 1: one-cycle pulse on each valid up/down step.
- `err` out 1: one-cycle pulse on an illegal transition.
- `err_cnt` out 4: illegal-transition count, saturates at 15.
- `lock` out 2: FSM state; 00 IDLE, 01 ACQ, 10 LOCK, 11 FAULT.

## Operation
- Gray to binary: `b2 = g2`, `b1 = g2^g1`, `b0 = b1^g0`. Legal sequence: 000,001,011,010,110,111,101,100, wrapping.
- Register `prev` holds the last binary sample. Compute `d = (b_now - prev) mod 8`:
  - d=1: up.
  - d=7: down.
  - d=0: hold.
  - d=2..6: illegal.
- IDLE, entered on reset or `clr`:
  - Next edge loads `prev`/`bin` from the input.
  - No `step`/`err` is issued.
  - Go to ACQ with run counter = 0.
- ACQ:
  - Up/down: `pos` ±1, `dir` updated, `step`=1, run+1. When run reaches `LOCK_N`, go to LOCK.
  - Hold: no change.
  - Illegal: `err`=1, `err_cnt`+1, go to FAULT.
- LOCK: same step/hold handling as ACQ. Illegal: `err`, `err_cnt`+1, go to FAULT.
- FAULT:
  - `pos` and `dir` are frozen and `step` stays 0.
  - `prev`/`bin` keep tracking the input.
  - Further illegal transitions still pulse `err` and increment `err_cnt`.
  - FAULT is left only via `clr` or `rst`.
- `pos` wraps modulo 2^`POS_W` in both directions (0 − 1 = all ones).
- `err_cnt` saturates at 15, with no wrap.

## Timing
- Reset values (async, while `rst`=0):
  - `pos`=0, `dir`=0, `step`=0, `err`=0, `err_cnt`=0.
  - `lock`=00, `bin`=000, `prev`=000, run=0.
- Latency: `g` stable before edge k gives `bin`, `pos`, `dir`, `step`, `err`, `err_cnt` and `lock` updated after edge k (1 edge).
- `step` and `err` are high for exactly one cycle per event. They are never both high.
- `clr`=1 at edge k:
  - Outputs take reset values, except that `bin`/`prev` load the current input.
  - `lock` = IDLE.
  - `clr` overrides a simultaneous step or illegal transition; no `step` or `err` pulse that cycle.
- `rst` asserted mid-operation takes effect immediately, regardless of `clk`. Deassertion is followed by an IDLE priming edge.
- The upstream counter changes `g` once per its clock. This block is on the same `clk`, so back-to-back steps on consecutive edges are legal.

## Configuration
- Macro `GRAY_TRK_SYNC_EN`.
- Defined: `g` passes through a 2-flop synchronizer before conversion.
  - Synchronizer flops reset to 000.
  - Latency becomes 3 edges.
  - Use when the counter runs in another clock domain.
- Undefined: `g` is used directly; latency is 1 edge.

## Test plan
- Reset, prime on g=000, then apply 001, 011, 010 on successive edges. Require:
  - `step` pulses three times, `dir`=1, `pos`=3.
  - `lock` goes 00→01→01→10 (`LOCK_N`=2).
- From LOCK at `pos`=3, apply the reverse sequence 011, 001, 000, 100. Require:
  - `dir`=0, `pos`=−1 (0xFF), `bin`=111 on the last edge.
- In LOCK, jump g from 010 to 101. Require:
  - `err` pulses once, `err_cnt`=1, `lock`=11.
  - Subsequent legal steps give `step`=0 and `pos` unchanged.
- Assert `clr` on the same edge as an illegal jump. Require:
  - No `err` pulse, `err_cnt`=0, `pos`=0, `lock`=00.
  - ACQ is reached on the next edge.
- Drive 17 illegal jumps in FAULT. Require `err_cnt` saturates at 15.
- Pulse `rst` low between clock edges mid-count. Require all outputs immediately at reset values, and a fresh priming edge afterwards.
- With `GRAY_TRK_SYNC_EN` defined, repeat the first test and check that each response is delayed by 2 additional edges.

Source files
------------

// File: rtl/gray_step_tracker.sv
// gray_step_tracker
// Samples a 3-bit Gray-code up/down counter every clock, converts it to binary,
// classifies each transition (up / down / hold / illegal), keeps a wrapping
// position count and qualifies the sequence with a small lock FSM.
// Optional feature: define GRAY_TRK_SYNC_EN to pass g through a 2-flop
// synchronizer. Use this when the counter lives in another clock domain.
// Latency grows from 1 to 3 edges in that build.

module gray_step_tracker #(
    parameter int POS_W  = 8,
    parameter int LOCK_N = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       g,
    input  logic             clr,
    output logic [2:0]       bin,
    output logic [POS_W-1:0] pos,
    output logic             dir,
    output logic             step,
    output logic             err,
    output logic [3:0]       err_cnt,
    output logic [1:0]       lock
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACQ    = 2'b01,
        LOCKED = 2'b10,
        FAULT  = 2'b11
    } state_t;

    state_t           state, state_nxt;
    logic [2:0]       prev, prev_nxt;
    logic [2:0]       run, run_nxt;
    logic [POS_W-1:0] pos_nxt;
    logic             dir_nxt, step_nxt, err_nxt;
    logic [3:0]       err_cnt_nxt;
    logic [2:0]       g_in;
    logic [2:0]       b_now;
    logic [2:0]       d;
    logic             is_up, is_dn, is_bad;

    function automatic logic [2:0] gray2bin(input logic [2:0] gv);
        logic [2:0] b;
        b[2] = gv[2];
        b[1] = b[2] ^ gv[1];
        b[0] = b[1] ^ gv[0];
        return b;
    endfunction

    function automatic logic [3:0] sat_inc4(input logic [3:0] x);
        return (x == 4'hF) ? x : x + 4'd1;
    endfunction

`ifdef GRAY_TRK_SYNC_EN
    logic [2:0] g_p0, g_p1;

    // Two-flop synchronizer for a counter running in a foreign clock domain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            g_p0 <= 3'b000;
            g_p1 <= 3'b000;
        end else begin
            g_p0 <= g;
            g_p1 <= g_p0;
        end
    end

    assign g_in = g_p1;
`else
    assign g_in = g;
`endif

    // Transition classification against the previous binary sample.
    // Modulo-8 difference: 1 is a step up, 7 a step down, 0 a hold, else illegal.
    always_comb begin
        b_now  = gray2bin(g_in);
        d      = b_now - prev;
        is_up  = (d == 3'd1);
        is_dn  = (d == 3'd7);
        is_bad = (d != 3'd0) && !is_up && !is_dn;
    end

    // Next-state and next-output logic for the lock FSM and its datapath.
    always_comb begin
        state_nxt   = state;
        prev_nxt    = b_now;
        run_nxt     = run;
        pos_nxt     = pos;
        dir_nxt     = dir;
        step_nxt    = 1'b0;
        err_nxt     = 1'b0;
        err_cnt_nxt = err_cnt;

        if (clr) begin
            // clr wins over any simultaneous step or illegal jump; prev still
            // loads so the IDLE priming edge has a sensible reference.
            state_nxt   = IDLE;
            run_nxt     = 3'd0;
            pos_nxt     = '0;
            dir_nxt     = 1'b0;
            err_cnt_nxt = 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    run_nxt   = 3'd0;
                    state_nxt = ACQ;
                end
                ACQ, LOCKED: begin
                    if (is_up || is_dn) begin
                        pos_nxt  = is_up ? pos + POS_W'(1) : pos - POS_W'(1);
                        dir_nxt  = is_up;
                        step_nxt = 1'b1;
                        if (state == ACQ) begin
                            run_nxt = run + 3'd1;
                            if ((run + 3'd1) == 3'(LOCK_N))
                                state_nxt = LOCKED;
                        end
                    end else if (is_bad) begin
                        err_nxt     = 1'b1;
                        err_cnt_nxt = sat_inc4(err_cnt);
                        state_nxt   = FAULT;
                    end
                end
                FAULT: begin
                    // Position is frozen; only illegal jumps are still reported.
                    if (is_bad) begin
                        err_nxt     = 1'b1;
                        err_cnt_nxt = sat_inc4(err_cnt);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Datapath and pulse registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev    <= 3'b000;
            run     <= 3'd0;
            pos     <= '0;
            dir     <= 1'b0;
            step    <= 1'b0;
            err     <= 1'b0;
            err_cnt <= 4'd0;
        end else begin
            prev    <= prev_nxt;
            run     <= run_nxt;
            pos     <= pos_nxt;
            dir     <= dir_nxt;
            step    <= step_nxt;
            err     <= err_nxt;
            err_cnt <= err_cnt_nxt;
        end
    end

    assign bin  = prev;
    assign lock = state;

endmodule
